// File: rtl/encdec_pkg.sv
// Shared types, register map and extended-Hamming (SECDED) helpers for the EncDec golden model.
// Codeword layout: bit i holds Hamming position i+1 for i < W-1; bit W-1 is the overall parity.
package encdec_pkg;

  localparam int unsigned MAX_W = 32;

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_DATA_IN  = 2'd1;
  localparam logic [1:0] REG_CW_WIDTH = 2'd2;
  localparam logic [1:0] REG_NOISE    = 2'd3;

  typedef enum logic [1:0] {
    MODE_ENC  = 2'd0,
    MODE_DEC  = 2'd1,
    MODE_FULL = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    CW_8  = 2'd0,
    CW_16 = 2'd1,
    CW_32 = 2'd2
  } cw_width_e;

  typedef struct packed {
    logic [MAX_W-1:0] data;
    logic [1:0]       nof;
  } exp_t;

  function automatic mode_e to_mode(input logic [1:0] v);
    case (v)
      2'd0:    return MODE_ENC;
      2'd1:    return MODE_DEC;
      default: return MODE_FULL;
    endcase
  endfunction

  function automatic int unsigned cw_bits(input logic [1:0] v);
    case (v)
      CW_8:    return 8;
      CW_16:   return 16;
      default: return 32;
    endcase
  endfunction

  function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return m[MAX_W-1:0];
  endfunction

  function automatic logic [MAX_W-1:0] hamming_encode(input logic [MAX_W-1:0] info,
                                                      input int unsigned w);
    logic [MAX_W-1:0] cw;
    logic [31:0]      pw;
    int unsigned      k;
    logic             par;
    cw = '0;
    k  = 0;
    for (int unsigned p = 1; p < MAX_W; p++) begin
      if (p < w && (p & (p - 1)) != 0) begin
        cw[5'(p - 1)] = info[5'(k)];
        k++;
      end
    end
    for (int unsigned j = 0; j < 5; j++) begin
      pw  = 32'd1 << j;
      par = 1'b0;
      for (int unsigned p = 1; p < MAX_W; p++) begin
        if (p < w && (p & pw) != 0) par ^= cw[5'(p - 1)];
      end
      if (pw < w) cw[5'(pw - 1)] = par;
    end
    cw[5'(w - 1)] = ^(cw & width_mask(w - 1));
    return cw;
  endfunction

  // Syndrome locates a single flip; overall parity separates single from double errors.
  function automatic exp_t hamming_decode(input logic [MAX_W-1:0] cw_in, input int unsigned w);
    logic [MAX_W-1:0] c;
    logic [MAX_W-1:0] d;
    logic [4:0]       syn;
    logic             par;
    int unsigned      k;
    exp_t             r;
    c   = cw_in & width_mask(w);
    syn = '0;
    for (int unsigned p = 1; p < MAX_W; p++) begin
      if (p < w && c[5'(p - 1)]) syn ^= 5'(p);
    end
    par = ^c;
    if (syn == '0 && !par) r.nof = 2'd0;
    else if (par)          r.nof = 2'd1;
    else                   r.nof = 2'd2;
    if (par && syn != '0) c[syn - 5'd1] = ~c[syn - 5'd1];
    d = '0;
    k = 0;
    for (int unsigned p = 1; p < MAX_W; p++) begin
      if (p < w && (p & (p - 1)) != 0) begin
        d[5'(k)] = c[5'(p - 1)];
        k++;
      end
    end
    r.data = (r.nof == 2'd2) ? '0 : d;
    return r;
  endfunction

endpackage

// File: rtl/encdec_gm_fifo.sv
// Bypass-free synchronous FIFO of expected results; a push when full succeeds only alongside a pop.
module encdec_gm_fifo
  import encdec_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  exp_t din,
  output exp_t dout,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  exp_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[AW'(i)] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/encdec_gm_scoreboard.sv
// Golden model + scoreboard for the EncDec SECDED DUT: mirrors APB registers, queues expected results.
// Optional ENCDEC_GM_ASSERT_EN: report failed compares and queue overflow through $error.
module encdec_gm_scoreboard
  import encdec_pkg::*;
#(
  parameter int unsigned AMBA_WORD       = 32,
  parameter int unsigned AMBA_ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  input  logic [DATA_WIDTH-1:0]      dut_data_out,
  input  logic                       dut_operation_done,
  input  logic [1:0]                 dut_num_of_errors,
  output logic [AMBA_WORD-1:0]       gm_PRDATA,
  output logic [DATA_WIDTH-1:0]      exp_data_out,
  output logic [1:0]                 exp_num_of_errors,
  output logic                       exp_valid,
  output logic                       mismatch,
  output logic                       unexpected_done,
  output logic                       fifo_overflow,
  output logic [CNT_WIDTH-1:0]       match_cnt,
  output logic [CNT_WIDTH-1:0]       mismatch_cnt
);

  logic [AMBA_WORD-1:0] ctrl_q, data_in_q, cw_width_q, noise_q;
  logic                 wr_en;
  logic [1:0]           wr_sel;
  logic                 unused_paddr;

  assign wr_en        = PSEL & PENABLE & PWRITE;
  assign wr_sel       = PADDR[3:2];
  assign unused_paddr = ^{PADDR[AMBA_ADDR_WIDTH-1:4], PADDR[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      data_in_q  <= '0;
      cw_width_q <= '0;
      noise_q    <= '0;
    end else if (wr_en) begin
      case (wr_sel)
        REG_CTRL:     ctrl_q     <= PWDATA;
        REG_DATA_IN:  data_in_q  <= PWDATA;
        REG_CW_WIDTH: cw_width_q <= PWDATA;
        default:      noise_q    <= PWDATA;
      endcase
    end
  end

  always_comb begin
    gm_PRDATA = '0;
    case (wr_sel)
      REG_CTRL:     gm_PRDATA = ctrl_q;
      REG_DATA_IN:  gm_PRDATA = data_in_q;
      REG_CW_WIDTH: gm_PRDATA = cw_width_q;
      default:      gm_PRDATA = noise_q;
    endcase
  end

  // Expected result for a CTRL write: new mode from PWDATA, other registers as currently held.
  int unsigned      w_cur;
  logic [MAX_W-1:0] enc_cw;
  exp_t             exp_calc;

  always_comb begin
    w_cur  = cw_bits(cw_width_q[1:0]);
    enc_cw = hamming_encode(MAX_W'(data_in_q), w_cur);
    case (to_mode(PWDATA[1:0]))
      MODE_ENC: exp_calc = '{data: enc_cw, nof: 2'd0};
      MODE_DEC: exp_calc = hamming_decode(MAX_W'(data_in_q) ^ MAX_W'(noise_q), w_cur);
      default:  exp_calc = hamming_decode(enc_cw ^ MAX_W'(noise_q), w_cur);
    endcase
  end

  logic push_q;
  exp_t push_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      push_q      <= wr_en && (wr_sel == REG_CTRL);
      push_data_q <= exp_calc;
    end
  end

  exp_t head;
  logic full, empty, cmp, pass, ovf;

  encdec_gm_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .pop   (cmp),
    .din   (push_data_q),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign cmp  = dut_operation_done & ~empty;
  assign ovf  = push_q & full & ~cmp;
  assign pass = (((MAX_W'(dut_data_out) ^ head.data) & width_mask(w_cur)) == '0) &&
                (dut_num_of_errors == head.nof);

  assign exp_valid         = ~empty;
  assign exp_data_out      = empty ? '0 : DATA_WIDTH'(head.data);
  assign exp_num_of_errors = empty ? 2'd0 : head.nof;

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch        <= 1'b0;
      unexpected_done <= 1'b0;
      fifo_overflow   <= 1'b0;
      match_cnt       <= '0;
      mismatch_cnt    <= '0;
    end else begin
      mismatch        <= cmp & ~pass;
      unexpected_done <= dut_operation_done & empty;
      if (ovf) fifo_overflow <= 1'b1;
      if (cmp && pass && match_cnt != '1)     match_cnt    <= match_cnt + CNT_WIDTH'(1);
      if (cmp && !pass && mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_WIDTH'(1);
    end
  end

`ifdef ENCDEC_GM_ASSERT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(cmp && !pass))
        else $error("%0t exp=%h/%0d act=%h/%0d mode=%0d W=%0d", $time, head.data, head.nof,
                    dut_data_out, dut_num_of_errors, ctrl_q[1:0], w_cur);
      assert (!(ovf && !fifo_overflow))
        else $error("%0t expected-result queue overflow", $time);
    end
  end
`endif

endmodule

// File: tb/tb_encdec_gm_scoreboard.sv
// Directed bench for encdec_gm_scoreboard: brute-force SECDED model + per-cycle compare process.
module tb_encdec_gm_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] dut_data_out;
  logic        dut_operation_done;
  logic [1:0]  dut_num_of_errors;
  logic [31:0] gm_PRDATA, exp_data_out;
  logic [1:0]  exp_num_of_errors;
  logic        exp_valid, mismatch, unexpected_done, fifo_overflow;
  logic [15:0] match_cnt, mismatch_cnt;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  encdec_gm_scoreboard dut (
    .clk(clk), .rst(rst), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .dut_data_out(dut_data_out), .dut_operation_done(dut_operation_done),
    .dut_num_of_errors(dut_num_of_errors), .gm_PRDATA(gm_PRDATA), .exp_data_out(exp_data_out),
    .exp_num_of_errors(exp_num_of_errors), .exp_valid(exp_valid), .mismatch(mismatch),
    .unexpected_done(unexpected_done), .fifo_overflow(fifo_overflow), .match_cnt(match_cnt),
    .mismatch_cnt(mismatch_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  function automatic logic [31:0] m_mask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Parity bits are the XOR of the positions of all set data bits.
  function automatic logic [31:0] m_encode(input logic [31:0] info, input int w);
    logic [31:0] cw;
    logic [4:0]  s;
    int          k;
    cw = '0; s = '0; k = 0;
    for (int pos = 1; pos < w; pos++) begin
      if (!is_pow2(pos)) begin
        if (info[5'(k)]) begin
          cw[5'(pos - 1)] = 1'b1;
          s ^= 5'(pos);
        end
        k++;
      end
    end
    for (int j = 0; j < 5; j++) if ((1 << j) < w) cw[5'((1 << j) - 1)] = s[j];
    cw[5'(w - 1)] = ^cw;
    return cw;
  endfunction

  function automatic logic [31:0] m_extract(input logic [31:0] cw, input int w);
    logic [31:0] d;
    int          k;
    d = '0; k = 0;
    for (int pos = 1; pos < w; pos++) begin
      if (!is_pow2(pos)) begin
        d[5'(k)] = cw[5'(pos - 1)];
        k++;
      end
    end
    return d;
  endfunction

  // Nearest-codeword search: valid -> 0 errors, one flip away -> 1, otherwise 2.
  task automatic m_decode(input logic [31:0] cw_in, input int w,
                          output logic [31:0] d, output logic [1:0] nof);
    logic [31:0] c, t;
    c = cw_in & m_mask(w);
    nof = 2'd2; d = '0;
    if (m_encode(m_extract(c, w), w) == c) begin
      nof = 2'd0; d = m_extract(c, w);
    end else begin
      for (int i = 0; i < w; i++) begin
        t = c ^ (32'd1 << i);
        if (nof == 2'd2 && m_encode(m_extract(t, w), w) == t) begin
          nof = 2'd1; d = m_extract(t, w);
        end
      end
    end
  endtask

  logic [31:0] m_data_in, m_cw, m_noise;
  logic [31:0] mq_data[$];
  logic [1:0]  mq_nof[$];
  logic        m_pend, m_mis_p, m_unexp, m_ovf;
  logic [31:0] m_pd;
  logic [1:0]  m_pn;
  logic [15:0] m_match, m_mism;

  function automatic int m_w();
    return (m_cw[1:0] == 2'd0) ? 8 : (m_cw[1:0] == 2'd1) ? 16 : 32;
  endfunction

  task automatic m_compute(input logic [1:0] mode, output logic [31:0] d, output logic [1:0] n);
    int w;
    w = m_w();
    if (mode == 2'd0) begin
      d = m_encode(m_data_in, w); n = 2'd0;
    end else if (mode == 2'd1) m_decode(m_data_in ^ m_noise, w, d, n);
    else                      m_decode(m_encode(m_data_in, w) ^ m_noise, w, d, n);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mq_data.delete(); mq_nof.delete();
      m_pend = 0; m_mis_p = 0; m_unexp = 0; m_ovf = 0;
      m_match = '0; m_mism = '0;
      m_data_in = '0; m_cw = '0; m_noise = '0;
    end else begin
      m_mis_p = 0; m_unexp = 0;
      if (dut_operation_done) begin
        if (mq_data.size() > 0) begin
          if (((dut_data_out ^ mq_data[0]) & m_mask(m_w())) == 0 && dut_num_of_errors == mq_nof[0]) begin
            if (m_match != 16'hFFFF) m_match++;
          end else begin
            if (m_mism != 16'hFFFF) m_mism++;
            m_mis_p = 1;
          end
          void'(mq_data.pop_front()); void'(mq_nof.pop_front());
        end else m_unexp = 1;
      end
      if (m_pend) begin
        if (mq_data.size() < 4) begin mq_data.push_back(m_pd); mq_nof.push_back(m_pn); end
        else m_ovf = 1;
      end
      m_pend = 0;
      if (PSEL && PENABLE && PWRITE) begin
        case (PADDR[3:2])
          2'd0: begin m_compute(PWDATA[1:0], m_pd, m_pn); m_pend = 1; end
          2'd1: m_data_in = PWDATA;
          2'd2: m_cw = PWDATA;
          default: m_noise = PWDATA;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("exp_valid", exp_valid, mq_data.size() != 0);
      if (mq_data.size() != 0) begin
        chk("exp_data_out", exp_data_out, mq_data[0]);
        chk("exp_nof", exp_num_of_errors, mq_nof[0]);
      end
      chk("mismatch", mismatch, m_mis_p);
      chk("unexpected_done", unexpected_done, m_unexp);
      chk("fifo_overflow", fifo_overflow, m_ovf);
      chk("match_cnt", match_cnt, m_match);
      chk("mismatch_cnt", mismatch_cnt, m_mism);
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    @(negedge clk);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 20'(off); PWDATA = d;
    @(negedge clk);
    PENABLE = 1;
    @(negedge clk);
    PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic done(input logic [31:0] d, input logic [1:0] n);
    @(negedge clk);
    dut_operation_done = 1; dut_data_out = d; dut_num_of_errors = n;
    @(negedge clk);
    dut_operation_done = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); @(negedge clk); rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; PADDR = '0; PSEL = 0; PENABLE = 0; PWRITE = 0; PWDATA = '0;
    dut_data_out = '0; dut_operation_done = 0; dut_num_of_errors = '0;
    @(negedge clk); @(negedge clk);
    mon_en = 1;
    rst = 0;
    chk("rst_exp_valid", exp_valid, 0);
    chk("rst_match_cnt", match_cnt, 0);
    chk("rst_overflow", fifo_overflow, 0);

    chk("pin_enc_0_w8", m_encode(32'h0, 8), 32'h0);
    chk("pin_enc_f_w8", m_encode(32'hF, 8), 32'hFF);
    chk("pin_enc_5_w16", m_encode(32'h5, 16), 32'h2D);

    // encode W=8 of zero
    wr(4'h8, 0); wr(4'h4, 0); wr(4'h0, 0);
    @(negedge clk);
    chk("enc0_valid", exp_valid, 1);
    chk("enc0_data", exp_data_out, 32'h0);
    chk("enc0_nof", exp_num_of_errors, 0);
    done(32'h0, 2'd0);
    chk("enc0_match", match_cnt, 1);

    // full channel W=16, single then double noise
    wr(4'h8, 1); wr(4'h4, 32'h5); wr(4'hC, 32'h1); wr(4'h0, 2);
    @(negedge clk);
    chk("prdata_ctrl", gm_PRDATA, 32'h2);
    chk("full1_data", exp_data_out, 32'h5);
    chk("full1_nof", exp_num_of_errors, 2'd1);
    done(32'h5, 2'd1);
    wr(4'hC, 32'h3); wr(4'h0, 2);
    @(negedge clk);
    chk("full2_data", exp_data_out, 32'h0);
    chk("full2_nof", exp_num_of_errors, 2'd2);
    done(32'h0, 2'd2);

    // decode W=16 of a clean codeword
    wr(4'h4, 32'h2D); wr(4'hC, 0); wr(4'h0, 1);
    @(negedge clk);
    chk("dec16_data", exp_data_out, 32'h5);
    done(32'h5, 2'd0);

    // decode W=32, DUT answers wrongly
    wr(4'h8, 2); wr(4'h4, m_encode(32'h123, 32)); wr(4'h0, 1);
    @(negedge clk);
    chk("dec32_data", exp_data_out, 32'h123);
    chk("dec32_nof", exp_num_of_errors, 2'd0);
    done(32'h124, 2'd0);
    chk("dec32_mismatch", mismatch, 1);
    chk("dec32_mismatch_cnt", mismatch_cnt, 1);
    chk("dec32_match_cnt", match_cnt, 4);

    // fill queue, overflow, then drain (upper junk above W=8 must be ignored)
    wr(4'h8, 0);
    for (int i = 0; i < 4; i++) begin
      wr(4'h4, 32'(i)); wr(4'h0, 0);
    end
    @(negedge clk);
    chk("q_valid", exp_valid, 1);
    chk("q_no_ovf", fifo_overflow, 0);
    wr(4'h4, 32'h4); wr(4'h0, 0);
    @(negedge clk);
    chk("q_ovf", fifo_overflow, 1);
    for (int i = 0; i < 4; i++) done(mq_data[0] | 32'hFFFF_FF00, mq_nof[0]);
    chk("q_match_cnt", match_cnt, 8);
    chk("q_empty", exp_valid, 0);

    // done with empty queue
    done(32'h0, 2'd0);
    chk("empty_unexp", unexpected_done, 1);
    chk("empty_match", match_cnt, 8);
    chk("empty_mism", mismatch_cnt, 1);

    // reset with pushes in the queue
    wr(4'h0, 0); wr(4'h0, 0);
    do_reset();
    chk("rst2_valid", exp_valid, 0);
    chk("rst2_ovf", fifo_overflow, 0);
    chk("rst2_match", match_cnt, 0);
    done(32'h0, 2'd0);
    chk("rst2_unexp", unexpected_done, 1);

    // push and pop on the same edge
    wr(4'h0, 0);
    @(negedge clk);
    fork
      wr(4'h0, 0);
      begin @(negedge clk); @(negedge clk); done(32'h0, 2'd0); end
    join
    chk("pp_valid", exp_valid, 1);
    chk("pp_match", match_cnt, 1);
    done(32'h0, 2'd0);
    chk("pp_match2", match_cnt, 2);
    @(negedge clk);
    chk("pp_empty", exp_valid, 0);

    mon_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
